// File: rtl/systolic_array_nxn_pkg.sv
// Shared FSM encoding and default sizing for the NxN systolic matrix-multiply block.
package systolic_array_nxn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_N    = 2;
  localparam int unsigned DEF_KMAX = 16;

  // Full-precision product plus enough headroom for KMAX accumulations.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned kmax);
    return 2 * dw + $clog2(kmax);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: forwards A right and B down one cycle, and accumulates a*b
// with optional saturation.
module systolic_pe
  import systolic_array_nxn_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned ACCW = acc_width(DEF_DW, DEF_KMAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            sat_mode,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [ACCW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [ACCW:0]   sum;

  always_comb begin
    prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
    sum  = {1'b0, acc} + {{(ACCW + 1 - 2 * DW){1'b0}}, prod};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)
        acc <= '0;
      else if (sat_mode && sum[ACCW])
        acc <= '1;
      else
        acc <= sum[ACCW-1:0];
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic array computing C = A*B over k_len slices, with
// input skew lines, a slice counter and the job FSM.
module systolic_array_nxn
  import systolic_array_nxn_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned N    = DEF_N,
  parameter int unsigned KMAX = DEF_KMAX,
  parameter int unsigned ACCW = acc_width(DW, KMAX)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  input  logic                      sat_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DW-1:0]           a_vec,
  input  logic [N*DW-1:0]           b_vec,
  output logic                      busy,
  output logic                      done,
  output logic [N*N*ACCW-1:0]       c_flat
);

  localparam int unsigned KW        = $clog2(KMAX + 1);
  localparam int unsigned DRAIN_LEN = 2 * N - 2;
  localparam int unsigned DCW       = $clog2(DRAIN_LEN);
  localparam logic [KW-1:0] KMAX_K  = KW'(KMAX);

  state_t          state;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   cnt;
  logic [DCW-1:0]  dcnt;
  logic            sat_q;
  logic            start_ok;
  logic            accept;
  logic            clr;

  logic [DW-1:0]   a_h [N][N+1];
  logic [DW-1:0]   b_v [N+1][N];
  logic [ACCW-1:0] acc_arr [N][N];
  logic [DW-1:0]   a_spill_unused [N];
  logic [DW-1:0]   b_spill_unused [N];

  always_comb begin
    start_ok = start && (k_len != '0) && (k_len <= KMAX_K);
    in_ready = (state == ST_LOAD);
    accept   = in_valid && in_ready;
    busy     = (state == ST_LOAD) || (state == ST_DRAIN);
    done     = (state == ST_DONE);
    clr      = (state == ST_IDLE) && start_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      k_q   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state <= ST_LOAD;
            k_q   <= k_len;
            sat_q <= sat_mode;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt <= cnt + KW'(1);
            if (cnt == k_q - KW'(1)) begin
              state <= ST_DRAIN;
              dcnt  <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt == DCW'(DRAIN_LEN - 1))
            state <= ST_DONE;
          else
            dcnt <= dcnt + DCW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operands are zero whenever no slice is accepted, so stalls and drain add nothing.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_inj;
    logic [DW-1:0] b_inj;
    assign a_inj = accept ? a_vec[i*DW +: DW] : '0;
    assign b_inj = accept ? b_vec[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_inj;
      assign b_v[0][0] = b_inj;
    end else begin : g_dly
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned k = 0; k < i; k++) begin
            a_sr[k] <= '0;
            b_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj;
          b_sr[0] <= b_inj;
          for (int unsigned k = 1; k < i; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
        end
      end
      assign a_h[i][0] = a_sr[i-1];
      assign b_v[0][i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .sat_mode (sat_q),
        .a_in     (a_h[i][j]),
        .b_in     (b_v[i][j]),
        .a_out    (a_h[i][j+1]),
        .b_out    (b_v[i+1][j]),
        .acc      (acc_arr[i][j])
      );
    end
    assign a_spill_unused[i] = a_h[i][N];
    assign b_spill_unused[i] = b_v[N][i];
  end

  always_comb begin
    c_flat = '0;
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        c_flat[(i*N+j)*ACCW +: ACCW] = acc_arr[i][j];
  end

endmodule

// File: doc/systolic_array_nxn.md
SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 Parameter DW, default 8: unsigned operand width in bits.
REQ-002 Parameter N, default 2: array dimension; the array holds N x N processing elements (PEs), N >= 2.
REQ-003 Parameter KMAX, default 16: maximum inner dimension (slices per job).
REQ-004 Parameter ACCW, default 2*DW+$clog2(KMAX): accumulator and result width per PE.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle job request, sampled in IDLE only.
REQ-008 k_len  in  $clog2(KMAX+1)  number of k-slices in the job, latched on accepted start.
REQ-009 sat_mode  in  1  1 = saturating accumulation, 0 = modulo-2^ACCW wrap; latched on accepted start.
REQ-010 in_valid  in  1  a_vec/b_vec carry a valid k-slice.
REQ-011 in_ready  out  1  block accepts a slice this cycle.
REQ-012 a_vec  in  N*DW  column k of A; element i at bits [i*DW +: DW].
REQ-013 b_vec  in  N*DW  row k of B; element j at bits [j*DW +: DW].
REQ-014 busy  out  1  high in LOAD and DRAIN.
REQ-015 done  out  1  one-cycle pulse; c_flat is valid from this cycle on.
REQ-016 c_flat  out  N*N*ACCW  C(i,j) at bits [(i*N+j)*ACCW +: ACCW]; held until the next accepted start.

Function
REQ-017 The FSM SHALL use states IDLE, LOAD, DRAIN, DONE.
REQ-018 IDLE -> LOAD on start=1 with k_len in 1..KMAX; this clears all accumulators and the slice counter.
REQ-019 In IDLE, start with k_len=0 or k_len>KMAX SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-020 in_ready SHALL be 1 only in LOAD; a slice is accepted on a clock edge with in_valid & in_ready.
REQ-021 In LOAD with in_valid=0, the FSM SHALL stall indefinitely with no accumulator change.
REQ-022 After the k_len-th accepted slice, LOAD -> DRAIN; no further slices are accepted.
REQ-023 Operand skew: the row-i operand SHALL be delayed i cycles and the column-j operand j cycles.
REQ-024 The skewed A operand SHALL propagate right one PE per cycle; the skewed B operand SHALL propagate down one PE per cycle.
REQ-025 During drain, zero operands SHALL be injected so that no spurious MAC changes any result.
REQ-026 DRAIN SHALL last exactly 2N-2 cycles, then -> DONE.
REQ-027 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-028 Latency: done SHALL assert exactly 2N-1 cycles after the edge that accepts the last slice.
REQ-029 Each PE SHALL compute acc += a*b at full precision (2*DW bits), zero-extended to ACCW.
REQ-030 With sat_mode=1, a sum exceeding 2^ACCW-1 SHALL clamp to 2^ACCW-1 and stay there.
REQ-031 With sat_mode=0, the sum SHALL wrap modulo 2^ACCW.
REQ-032 start asserted while in LOAD, DRAIN or DONE SHALL be ignored.
REQ-033 start in the cycle after done SHALL be accepted normally, giving back-to-back jobs.

Reset
REQ-034 While rst=0: state=IDLE, and all accumulators, skew registers, pipeline registers and counters = 0.
REQ-035 While rst=0: in_ready=0, busy=0, done=0, c_flat=0.
REQ-036 Reset mid-job SHALL abort the job with no done pulse; the first edge after release SHALL be in IDLE.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding and the default-width helper constants.
REQ-038 One sub-module, systolic_pe, SHALL contain the registered a/b forwarding, MAC, saturation and clear; the top SHALL instantiate it N*N times via generate.
REQ-039 The skew delay lines, slice counter and FSM SHALL reside in the top module.

Verification
REQ-040 N=2, DW=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]], k_len=2, slices fed continuously -> C=[[19,22],[43,50]]; done 3 cycles after the last accept.
REQ-041 N=2, ACCW=16, all operands 255, k_len=2 -> sat_mode=1 gives 65535 in every C; sat_mode=0 gives 64514.
REQ-042 in_valid toggling 1,0,0,1 over the job of REQ-040 -> same results, busy held high throughout, in_ready high in LOAD only.
REQ-043 start with k_len=0 -> stays IDLE, busy=0, no done; a subsequent valid start is accepted.
REQ-044 rst=0 asserted mid-DRAIN -> done never pulses and c_flat=0; a new job then yields correct results.
REQ-045 N=4, random 8-bit A/B, k_len=KMAX, back-to-back jobs -> c_flat matches the reference model; done latency 7 cycles.
